// File: rtl/adder_arbiter.sv
// adder_arbiter
// Round-robin arbiter that shares one 16-bit ripple-carry adder among
// NUM_REQ requesters. The winner's operands are added in the cycle they are
// accepted. The sum, the carry-out and the requester id are stored in a
// single-entry response buffer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand valid
//   req_a      packed operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      packed operand B, same packing
//   req_ready  per-requester accept, one-hot or zero
//   rsp_valid  response buffer holds a result
//   rsp_sum    (a+b) mod 2^16
//   rsp_carry  carry-out of the add
//   rsp_id     requester that produced the buffered result
//   rsp_ready  consumer takes the buffered result
//   op_count   number of accepted operations, wraps at 2^16
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic [ID_W-1:0]          rsp_id,
  input  logic                     rsp_ready,
  output logic [15:0]              op_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [15:0]       opCount_q, opCount_d;
  logic [WIDTH-1:0]  rspSum_q;
  logic              rspCarry_q;
  logic [ID_W-1:0]   rspId_q;

  logic              grantFound;
  logic [ID_W-1:0]   grantIdx;
  int                scanIdx;
  logic              canAccept;
  logic              accept;
  logic [WIDTH-1:0]  opA, opB;
  logic [WIDTH-1:0]  sumBits;
  logic [WIDTH:0]    carryChain;

  // Cyclic priority search. The scan starts at the pointer and wraps
  // modulo NUM_REQ. The first valid requester it finds wins.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    scanIdx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scanIdx = int'(ptr_q) + k;
      if (scanIdx >= NUM_REQ) scanIdx = scanIdx - NUM_REQ;
      if (!grantFound && req_valid[ID_W'(scanIdx)]) begin
        grantFound = 1'b1;
        grantIdx   = ID_W'(scanIdx);
      end
    end
  end

  // The buffer can take a new result if it is empty or is being drained on
  // this same edge. This gives back-to-back throughput. rst_n gates the
  // handshake so that nothing is offered while the block is held in reset.
  always_comb begin
    canAccept = (state_q == EMPTY) | rsp_ready;
    accept    = rst_n & canAccept & grantFound;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grantIdx == ID_W'(i));
    end
  end

  // Operand mux for the granted requester, followed by the shared
  // ripple-carry adder with carry-in 0. The carry chain is built
  // explicitly, bit by bit.
  always_comb begin
    opA = '0;
    opB = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantIdx == ID_W'(i)) begin
        opA = req_a[i*WIDTH +: WIDTH];
        opB = req_b[i*WIDTH +: WIDTH];
      end
    end
    carryChain    = '0;
    carryChain[0] = 1'b0;
    sumBits       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sumBits[i]      = opA[i] ^ opB[i] ^ carryChain[i];
      carryChain[i+1] = (opA[i] & opB[i]) | (carryChain[i] & (opA[i] ^ opB[i]));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // FSM next state. If an accept happens while the buffer is full, the
  // buffer stays FULL and its contents are replaced. Without an accept,
  // the buffer empties once the consumer takes the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (!accept && rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // FSM outputs.
  always_comb begin
    rsp_valid = (state_q == FULL);
  end

  // Next pointer and next counter. Both move only on an accept. The
  // pointer goes to the requester just after the winner.
  always_comb begin
    ptr_d     = ptr_q;
    opCount_d = opCount_q;
    if (accept) begin
      ptr_d     = (grantIdx == ID_W'(NUM_REQ-1)) ? '0 : grantIdx + 1'b1;
      opCount_d = opCount_q + 16'd1;
    end
  end

  // Response buffer, pointer and counter. The buffer is loaded only on an
  // accept, so it holds its contents under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      opCount_q  <= '0;
      rspSum_q   <= '0;
      rspCarry_q <= 1'b0;
      rspId_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      opCount_q <= opCount_d;
      if (accept) begin
        rspSum_q   <= sumBits;
        rspCarry_q <= carryChain[WIDTH];
        rspId_q    <= grantIdx;
      end
    end
  end

  assign rsp_sum   = rspSum_q;
  assign rsp_carry = rspCarry_q;
  assign rsp_id    = rspId_q;
  assign op_count  = opCount_q;

endmodule
